rv32_hazard_ctrl: RTL and testbench
===================================

# rv32_hazard_ctrl

Pipeline hazard controller for the RV32 core. It generates per-stage stall and flush controls for the fetch, decode, execute and mem stages. Beyond load-use interlock and taken-branch flush, it adds:
- a configurable multi-bubble load-use interlock;
- instruction-bus and data-bus wait states;
- multi-cycle execute-unit back-pressure;
- suppression of stale fetch responses after a redirect;
- wrapping performance counters.

It sits beside the pipeline registers, and every stage register in the core takes its hold and bubble controls from this block.

## Interface
Parameters:
- LOAD_USE_BUBBLES, 1: bubbles inserted between a load and a dependent instruction. Legal range 1..15.
- PERF_WIDTH, 32: width of each performance counter.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- decode_rs1_in, decode_rs2_in  in  5  source registers of the instruction in fetch->decode.
- decode_rs1_read_in, decode_rs2_read_in  in  1  the corresponding source is actually read.
- decode_mem_read_in  in  1  the instruction in decode->execute is a load.
- decode_rd_in  in  5  destination of the instruction in decode->execute.
- decode_rd_write_in  in  1  that instruction writes rd.
- instr_ready_in  in  1  instruction bus returns a word this cycle.
- execute_busy_in  in  1  multi-cycle unit (mul/div) is still computing.
- mem_access_in  in  1  mem stage has a data-bus access.
- data_ready_in  in  1  data bus completes the access.
- mem_branch_taken_in  in  1  taken branch/jump resolved in mem.
- fetch_stall_out, decode_stall_out, execute_stall_out, mem_stall_out  out  1  hold the stage's output register.
- fetch_flush_out, decode_flush_out, execute_flush_out, mem_flush_out  out  1  load a bubble into the stage's output register.
- perf_bubble_count_out  out  PERF_WIDTH  load-use bubble cycles.
- perf_branch_count_out  out  PERF_WIDTH  effective taken branches.

## Operation
Internal state:
- lu_cnt: 4 bits, counts remaining load-use bubbles.
- branch_pending: 1 bit, an outstanding fetch belongs to the old path.
- The two performance counters.

Combinational terms:
- mem_stall = mem_access_in && !data_ready_in.
- branch_eff = mem_branch_taken_in && !mem_stall. A taken branch is only honoured when mem advances.
- lu_hit = decode_mem_read_in && decode_rd_write_in && decode_rd_in != 0, and at least one of the following holds:
  - decode_rs1_read_in && rs1 == rd;
  - decode_rs2_read_in && rs2 == rd.
- load_wait = (lu_hit || lu_cnt != 0) && !branch_eff.

Outputs:
- mem_stall_out = mem_stall.
- execute_stall_out = mem_stall || execute_busy_in.
- decode_stall_out = execute_stall_out.
- fetch_stall_out = decode_stall_out || load_wait || !instr_ready_in.
- fetch_flush_out = branch_eff || (branch_pending && instr_ready_in).
- decode_flush_out = (fetch_stall_out && !decode_stall_out) || branch_eff.
- execute_flush_out = branch_eff.
- mem_flush_out = execute_stall_out && !mem_stall.
- Flush has priority over stall in every stage register when both are asserted.

lu_cnt update, first matching rule wins:
1. branch_eff: lu_cnt <= 0.
2. decode_stall_out: hold.
3. lu_hit && lu_cnt == 0: lu_cnt <= LOAD_USE_BUBBLES-1.
4. lu_cnt != 0: decrement.

branch_pending update:
- Set on branch_eff && !instr_ready_in.
- Otherwise cleared on instr_ready_in.
- Otherwise hold.
- A second branch_eff while the flag is set keeps it set.

Performance counters:
- perf_bubble_count increments on every cycle with load_wait && !decode_stall_out.
- perf_branch_count increments on branch_eff.
- Both wrap modulo 2^PERF_WIDTH. All-ones + 1 = 0, with no sticky flag.

## Timing
- Stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
- State and counters update on the rising edge of clk.
- reset_n low clears lu_cnt, branch_pending and both counters immediately, without waiting for a clock edge. This applies mid-stall as well; the bubble sequence is abandoned.
- Outputs with all inputs idle (instr_ready_in=1, everything else 0, state reset): all stall and flush outputs are 0, and both counters are 0.
- Load-use: exactly LOAD_USE_BUBBLES cycles with decode_flush_out=1, counted only on cycles where execute is not stalled.
- execute_busy_in for N cycles holds decode and execute for N cycles, and mem_flush_out is asserted for those N cycles.
- Data-bus wait: mem_stall_out stays asserted until data_ready_in, and branch_eff is deferred to the cycle data_ready_in is seen.
- Stale fetch: after a redirect issued while the fetch was outstanding, exactly one returning word is flushed.

## Test plan
- LOAD_USE_BUBBLES=1, load to x5 in decode->execute, rs1=5 with rs1_read=1 -> one cycle of fetch_stall_out=1 and decode_flush_out=1; perf_bubble_count_out=1.
- LOAD_USE_BUBBLES=3, same hazard with execute_busy_in=1 on the second cycle -> 3 bubbles spread over 4 cycles; lu_cnt frozen during the busy cycle; counter reads 3.
- rd=0, or rs1=5 with rs1_read=0 -> no stall.
- mem_branch_taken_in=1 with mem_access_in=1, data_ready_in=0 for 2 cycles -> no flushes during those cycles; flushes on the third cycle when data_ready_in=1; perf_branch_count_out=1.
- Branch with instr_ready_in=0, ready returns 3 cycles later -> fetch_flush_out=1 in the branch cycle and again on the ready cycle; branch_pending=0 afterwards.
- PERF_WIDTH=4, 17 branches -> count reads 1. Assert reset_n mid-bubble with LOAD_USE_BUBBLES=4 -> lu_cnt=0 and counters=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rv32_hazard_ctrl.sv
// rv32_hazard_ctrl
//
// Pipeline hazard controller for the RV32 core. It produces per-stage hold
// (stall) and bubble (flush) controls for the fetch, decode, execute and mem
// stage output registers. It covers the following cases:
//   - a multi-bubble load-use interlock;
//   - instruction-bus and data-bus wait states;
//   - back-pressure from a multi-cycle execute unit;
//   - suppression of the stale fetch word that returns after a redirect;
//   - two wrapping performance counters.
//
// Parameters:
//   LOAD_USE_BUBBLES  bubbles between a load and its dependent (1..15)
//   PERF_WIDTH        width of each performance counter
//
// Ports:
//   clk, reset_n                    core clock, asynchronous active-low reset
//   decode_rs1_in/decode_rs2_in     sources of the instruction in fetch->decode
//   decode_rs1_read_in/_rs2_read_in the corresponding source is really read
//   decode_mem_read_in              instruction in decode->execute is a load
//   decode_rd_in, decode_rd_write_in  its destination and write enable
//   instr_ready_in                  instruction bus returns a word this cycle
//   execute_busy_in                 multi-cycle execute unit still computing
//   mem_access_in, data_ready_in    data-bus access in mem / access completes
//   mem_branch_taken_in             taken branch/jump resolved in mem
//   *_stall_out                     hold the stage's output register
//   *_flush_out                     load a bubble (flush wins over stall)
//   perf_bubble_count_out           load-use bubble cycles (wrapping)
//   perf_branch_count_out           honoured taken branches (wrapping)
//
// Stall and flush outputs are purely combinational (zero-cycle latency).
// State and counters update on the rising edge of clk.

module rv32_hazard_ctrl #(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned PERF_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4:0]            decode_rs1_in,
    input  logic [4:0]            decode_rs2_in,
    input  logic                  decode_rs1_read_in,
    input  logic                  decode_rs2_read_in,
    input  logic                  decode_mem_read_in,
    input  logic [4:0]            decode_rd_in,
    input  logic                  decode_rd_write_in,
    input  logic                  instr_ready_in,
    input  logic                  execute_busy_in,
    input  logic                  mem_access_in,
    input  logic                  data_ready_in,
    input  logic                  mem_branch_taken_in,
    output logic                  fetch_stall_out,
    output logic                  decode_stall_out,
    output logic                  execute_stall_out,
    output logic                  mem_stall_out,
    output logic                  fetch_flush_out,
    output logic                  decode_flush_out,
    output logic                  execute_flush_out,
    output logic                  mem_flush_out,
    output logic [PERF_WIDTH-1:0] perf_bubble_count_out,
    output logic [PERF_WIDTH-1:0] perf_branch_count_out
);

    // Reload value: the hit cycle itself is the first bubble.
    localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_BUBBLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]            lu_cnt_reg;
    logic [3:0]            lu_cnt_next;
    logic                  branch_pending_reg;
    logic                  branch_pending_next;
    logic [PERF_WIDTH-1:0] perf_bubble_reg;
    logic [PERF_WIDTH-1:0] perf_bubble_next;
    logic [PERF_WIDTH-1:0] perf_branch_reg;
    logic [PERF_WIDTH-1:0] perf_branch_next;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    logic       mem_stall;
    logic       exe_stall;
    logic       branch_eff;
    logic       lu_hit;
    logic       load_wait;
    logic       bubble_inc;
    logic [1:0] src_read;
    logic [1:0] src_match;
    logic [1:0][4:0] src_reg;

    assign src_reg[0]  = decode_rs1_in;
    assign src_reg[1]  = decode_rs2_in;
    assign src_read[0] = decode_rs1_read_in;
    assign src_read[1] = decode_rs2_read_in;

    // One comparator per source operand against the load destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_read[gi] && (src_reg[gi] == decode_rd_in);
        end
    endgenerate

    assign mem_stall  = mem_access_in && !data_ready_in;
    // A taken branch is only honoured in the cycle mem actually advances.
    assign branch_eff = mem_branch_taken_in && !mem_stall;
    assign lu_hit     = decode_mem_read_in && decode_rd_write_in &&
                        (decode_rd_in != 5'd0) && (|src_match);
    // A redirect discards the dependent instruction, so it also cancels
    // any interlock in progress.
    assign load_wait  = (lu_hit || (lu_cnt_reg != 4'd0)) && !branch_eff;
    assign exe_stall  = mem_stall || execute_busy_in;

    // ------------------------------------------------------------------
    // Stage controls
    // ------------------------------------------------------------------
    assign mem_stall_out     = mem_stall;
    assign execute_stall_out = exe_stall;
    assign decode_stall_out  = exe_stall;
    assign fetch_stall_out   = exe_stall || load_wait || !instr_ready_in;
    // The word returning after a redirect belongs to the old path.
    assign fetch_flush_out   = branch_eff || (branch_pending_reg && instr_ready_in);
    // Decode emits a bubble whenever fetch holds but decode itself moves on.
    assign decode_flush_out  = (fetch_stall_out && !exe_stall) || branch_eff;
    assign execute_flush_out = branch_eff;
    // Execute holding while mem drains: mem must take a bubble, not a copy.
    assign mem_flush_out     = exe_stall && !mem_stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        lu_cnt_next = lu_cnt_reg;
        if (branch_eff) begin
            lu_cnt_next = 4'd0;
        end else if (exe_stall) begin
            // Bubbles only count on cycles where decode actually advances.
            lu_cnt_next = lu_cnt_reg;
        end else if (lu_hit && (lu_cnt_reg == 4'd0)) begin
            lu_cnt_next = LU_RELOAD;
        end else if (lu_cnt_reg != 4'd0) begin
            lu_cnt_next = lu_cnt_reg - 4'd1;
        end
    end

    always_comb begin
        branch_pending_next = branch_pending_reg;
        if (branch_eff && !instr_ready_in) begin
            branch_pending_next = 1'b1;
        end else if (instr_ready_in) begin
            branch_pending_next = 1'b0;
        end
    end

    assign bubble_inc       = load_wait && !exe_stall;
    // Counters wrap naturally at 2^PERF_WIDTH.
    assign perf_bubble_next = perf_bubble_reg + {{(PERF_WIDTH-1){1'b0}}, bubble_inc};
    assign perf_branch_next = perf_branch_reg + {{(PERF_WIDTH-1){1'b0}}, branch_eff};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lu_cnt_reg         <= 4'd0;
            branch_pending_reg <= 1'b0;
            perf_bubble_reg    <= '0;
            perf_branch_reg    <= '0;
        end else begin
            lu_cnt_reg         <= lu_cnt_next;
            branch_pending_reg <= branch_pending_next;
            perf_bubble_reg    <= perf_bubble_next;
            perf_branch_reg    <= perf_branch_next;
        end
    end

    assign perf_bubble_count_out = perf_bubble_reg;
    assign perf_branch_count_out = perf_branch_reg;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed testbench for rv32_hazard_ctrl. Three instances share one set of
// inputs and differ only in parameters:
//   u_dut_a: LOAD_USE_BUBBLES=1, PERF_WIDTH=32
//   u_dut_b: LOAD_USE_BUBBLES=3, PERF_WIDTH=4
//   u_dut_c: LOAD_USE_BUBBLES=4, PERF_WIDTH=8
// Each scenario starts from reset and checks only the instance it targets.
// Stage flags are packed as
// {fetch_stall, decode_stall, execute_stall, mem_stall,
//  fetch_flush, decode_flush, execute_flush, mem_flush}.

module tb_rv32_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_read, rs2_read, mem_read, rd_write;
    logic       instr_ready, execute_busy, mem_access, data_ready, branch_taken;

    logic [7:0]  flags_a, flags_b, flags_c;
    logic [31:0] bub_a, br_a;
    logic [3:0]  bub_b, br_b;
    logic [7:0]  bub_c, br_c;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .PERF_WIDTH(32)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .decode_rs1_read_in(rs1_read), .decode_rs2_read_in(rs2_read),
        .decode_mem_read_in(mem_read), .decode_rd_in(rd), .decode_rd_write_in(rd_write),
        .instr_ready_in(instr_ready), .execute_busy_in(execute_busy),
        .mem_access_in(mem_access), .data_ready_in(data_ready),
        .mem_branch_taken_in(branch_taken),
        .fetch_stall_out(flags_a[7]), .decode_stall_out(flags_a[6]),
        .execute_stall_out(flags_a[5]), .mem_stall_out(flags_a[4]),
        .fetch_flush_out(flags_a[3]), .decode_flush_out(flags_a[2]),
        .execute_flush_out(flags_a[1]), .mem_flush_out(flags_a[0]),
        .perf_bubble_count_out(bub_a), .perf_branch_count_out(br_a)
    );

    rv32_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .PERF_WIDTH(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .decode_rs1_read_in(rs1_read), .decode_rs2_read_in(rs2_read),
        .decode_mem_read_in(mem_read), .decode_rd_in(rd), .decode_rd_write_in(rd_write),
        .instr_ready_in(instr_ready), .execute_busy_in(execute_busy),
        .mem_access_in(mem_access), .data_ready_in(data_ready),
        .mem_branch_taken_in(branch_taken),
        .fetch_stall_out(flags_b[7]), .decode_stall_out(flags_b[6]),
        .execute_stall_out(flags_b[5]), .mem_stall_out(flags_b[4]),
        .fetch_flush_out(flags_b[3]), .decode_flush_out(flags_b[2]),
        .execute_flush_out(flags_b[1]), .mem_flush_out(flags_b[0]),
        .perf_bubble_count_out(bub_b), .perf_branch_count_out(br_b)
    );

    rv32_hazard_ctrl #(.LOAD_USE_BUBBLES(4), .PERF_WIDTH(8)) u_dut_c (
        .clk(clk), .reset_n(reset_n),
        .decode_rs1_in(rs1), .decode_rs2_in(rs2),
        .decode_rs1_read_in(rs1_read), .decode_rs2_read_in(rs2_read),
        .decode_mem_read_in(mem_read), .decode_rd_in(rd), .decode_rd_write_in(rd_write),
        .instr_ready_in(instr_ready), .execute_busy_in(execute_busy),
        .mem_access_in(mem_access), .data_ready_in(data_ready),
        .mem_branch_taken_in(branch_taken),
        .fetch_stall_out(flags_c[7]), .decode_stall_out(flags_c[6]),
        .execute_stall_out(flags_c[5]), .mem_stall_out(flags_c[4]),
        .fetch_flush_out(flags_c[3]), .decode_flush_out(flags_c[2]),
        .execute_flush_out(flags_c[1]), .mem_flush_out(flags_c[0]),
        .perf_bubble_count_out(bub_c), .perf_branch_count_out(br_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_read = 1'b0; rs2_read = 1'b0; mem_read = 1'b0; rd_write = 1'b0;
        instr_ready = 1'b1; execute_busy = 1'b0;
        mem_access = 1'b0; data_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] ld_rd, input logic [4:0] s1, input logic s1_rd,
                            input logic [4:0] s2, input logic s2_rd);
        mem_read = 1'b1; rd_write = 1'b1; rd = ld_rd;
        rs1 = s1; rs1_read = s1_rd; rs2 = s2; rs2_read = s2_rd;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        #12;
        // Reset state with idle inputs.
        check("reset_flags_a", 32'(flags_a), 32'h00);
        check("reset_bub_a",   bub_a, 32'd0);
        check("reset_br_a",    br_a,  32'd0);
        reset_n = 1'b1;
        tick();
        set_idle(); #1;
        check("idle_flags_a", 32'(flags_a), 32'h00);

        // 1) Single-bubble load-use on rs1.
        do_reset();
        set_idle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #1;
        check("lu1_hit_a", 32'(flags_a), 32'b1000_0100);
        tick();
        set_idle(); #1;
        check("lu1_after_a", 32'(flags_a), 32'h00);
        check("lu1_bub_a", bub_a, 32'd1);

        // 2) Three bubbles with execute busy on the second cycle.
        do_reset();
        set_idle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #1;
        check("lu3_c1_b", 32'(flags_b), 32'b1000_0100);
        tick();
        set_idle(); execute_busy = 1'b1; #1;
        check("lu3_busy_b", 32'(flags_b), 32'b1110_0001);
        tick();
        set_idle(); #1;
        check("lu3_c3_b", 32'(flags_b), 32'b1000_0100);
        tick();
        set_idle(); #1;
        check("lu3_c4_b", 32'(flags_b), 32'b1000_0100);
        tick();
        set_idle(); #1;
        check("lu3_c5_b", 32'(flags_b), 32'h00);
        check("lu3_bub_b", 32'(bub_b), 32'd3);

        // 3) Cases that must not interlock, then an rs2 hit.
        do_reset();
        set_idle(); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #1;
        check("nolu_rd0_b", 32'(flags_b), 32'h00);
        set_idle(); set_load(5'd5, 5'd5, 1'b0, 5'd0, 1'b0); #1;
        check("nolu_noread_b", 32'(flags_b), 32'h00);
        set_idle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); rd_write = 1'b0; #1;
        check("nolu_nowrite_b", 32'(flags_b), 32'h00);
        set_idle(); set_load(5'd7, 5'd5, 1'b1, 5'd7, 1'b1); #1;
        check("lu_rs2_b", 32'(flags_b), 32'b1000_0100);

        // 4) Taken branch deferred by a data-bus wait.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_idle(); branch_taken = 1'b1; mem_access = 1'b1; #1;
            check($sformatf("brwait_c%0d_a", i), 32'(flags_a), 32'b1111_0000);
            tick();
        end
        set_idle(); branch_taken = 1'b1; mem_access = 1'b1; data_ready = 1'b1; #1;
        check("brwait_go_a", 32'(flags_a), 32'b0000_1110);
        tick();
        set_idle(); #1;
        check("brwait_after_a", 32'(flags_a), 32'h00);
        check("brwait_br_a", br_a, 32'd1);

        // 5) Redirect while fetch outstanding: stale word flushed once.
        do_reset();
        set_idle(); branch_taken = 1'b1; instr_ready = 1'b0; #1;
        check("stale_br_a", 32'(flags_a), 32'b1000_1110);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_idle(); instr_ready = 1'b0; #1;
            check($sformatf("stale_wait%0d_a", i), 32'(flags_a), 32'b1000_0100);
            tick();
        end
        set_idle(); #1;
        check("stale_ret_a", 32'(flags_a), 32'b0000_1000);
        tick();
        set_idle(); #1;
        check("stale_after_a", 32'(flags_a), 32'h00);

        // 6) Counter wrap: 17 branches.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_idle(); branch_taken = 1'b1;
            tick();
        end
        set_idle(); #1;
        check("wrap_br_b", 32'(br_b), 32'd1);
        check("wrap_br_a", br_a, 32'd17);

        // 7) Asynchronous reset in the middle of a 4-bubble interlock.
        do_reset();
        set_idle(); branch_taken = 1'b1; #1;
        check("ares_br_c", 32'(flags_c), 32'b0000_1110);
        tick();
        set_idle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #1;
        check("ares_hit_c", 32'(flags_c), 32'b1000_0100);
        tick();
        set_idle(); #1;
        check("ares_b2_c", 32'(flags_c), 32'b1000_0100);
        check("ares_brcnt_c", 32'(br_c), 32'd1);
        check("ares_bub1_c", 32'(bub_c), 32'd1);
        tick();
        set_idle(); #1;
        check("ares_bub2_c", 32'(bub_c), 32'd2);
        check("ares_b3_c", 32'(flags_c), 32'b1000_0100);
        #1 reset_n = 1'b0;
        #1;
        check("ares_flags_c", 32'(flags_c), 32'h00);
        check("ares_bub0_c", 32'(bub_c), 32'd0);
        check("ares_br0_c", 32'(br_c), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        set_idle(); #1;
        check("ares_post_c", 32'(flags_c), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
